// File: rtl/pipe_mux_n.sv
// Registered N-way channel selector with valid/ready output handshake and stall/flush control.
// Defining PIPE_MUX_SKID_EN adds a one-entry skid register so in_ready no longer depends on out_ready.
module pipe_mux_n #(
    parameter int              WIDTH     = 32,
    parameter int              N         = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    localparam int             SEL_W     = $clog2(N)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N*WIDTH-1:0] in_bus,
    input  logic [SEL_W-1:0]   sel,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               flush,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               sel_err
);

    // N always fits in SEL_W+1 bits, so the compare needs no wider operands.
    function automatic logic sel_bad(input logic [SEL_W-1:0] s);
        return {1'b0, s} >= (SEL_W+1)'(N);
    endfunction

    // Out-of-range selects fall back to channel 0.
    function automatic logic [WIDTH-1:0] select_channel(input logic [N*WIDTH-1:0] bus,
                                                        input logic [SEL_W-1:0]   s);
        logic [WIDTH-1:0] r;
        r = bus[WIDTH-1:0];
        for (int k = 1; k < N; k++) begin
            if (s == SEL_W'(k)) r = bus[k*WIDTH +: WIDTH];
        end
        return r;
    endfunction

    logic             accept;
    logic [WIDTH-1:0] mux_data;

    assign accept   = in_valid & in_ready;
    assign mux_data = select_channel(in_bus, sel);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)      sel_err <= 1'b0;
        else if (flush) sel_err <= 1'b0;
        else            sel_err <= accept & sel_bad(sel);
    end

`ifdef PIPE_MUX_SKID_EN
    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

    state_t           state, state_nxt;
    logic             load_in, load_from_skid, load_skid;
    logic [WIDTH-1:0] skid_data;

    assign in_ready  = (state != TWO);
    assign out_valid = (state != EMPTY);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)      state <= EMPTY;
        else if (flush) state <= EMPTY;
        else            state <= state_nxt;
    end

    always_comb begin
        state_nxt      = state;
        load_in        = 1'b0;
        load_from_skid = 1'b0;
        load_skid      = 1'b0;
        case (state)
            EMPTY: begin
                if (accept) begin
                    state_nxt = ONE;
                    load_in   = 1'b1;
                end
            end
            ONE: begin
                if (accept && !out_ready) begin
                    state_nxt = TWO;
                    load_skid = 1'b1;
                end else if (accept) begin
                    load_in = 1'b1;
                end else if (out_ready) begin
                    state_nxt = EMPTY;
                end
            end
            TWO: begin
                if (out_ready) begin
                    state_nxt      = ONE;
                    load_from_skid = 1'b1;
                end
            end
            default: state_nxt = EMPTY;
        endcase
    end

    // Output and skid registers; the skid word reaches the output only after TWO drains.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_data  <= RESET_VAL;
            skid_data <= RESET_VAL;
        end else if (flush) begin
            out_data  <= RESET_VAL;
            skid_data <= RESET_VAL;
        end else begin
            if (load_in)             out_data <= mux_data;
            else if (load_from_skid) out_data <= skid_data;
            if (load_skid)           skid_data <= mux_data;
        end
    end
`else
    assign in_ready = !out_valid | out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= RESET_VAL;
        end else if (flush) begin
            out_valid <= 1'b0;
            out_data  <= RESET_VAL;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_data  <= mux_data;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
`endif

endmodule
